// File: rtl/stopwatch_trigger_gen.sv
// Push-button front end for the stopwatch: synchronises and debounces btn_in, then
// classifies each press as short (trigger pulse, toggle run) or long (clear pulse, stop).
module stopwatch_trigger_gen #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
  parameter int unsigned CNT_W             = 27
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic trigger_out,
  output logic clear_out,
  output logic run_en
);

  typedef enum logic [1:0] {
    REL      = 2'd0,
    HELD     = 2'd1,
    LONGHELD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             s_meta;
  logic             s;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] hcnt;
  state_t           state;

  logic accept;
  logic level_rise;
  logic level_fall;

  // accept marks the edge on which btn_level takes the new value; the FSM reacts on
  // that same edge so its pulses line up with the btn_level transition.
  assign accept     = (s != btn_level) && (dcnt == DEB_LAST);
  assign level_rise = accept && s;
  assign level_fall = accept && !s;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
    end else begin
      s_meta <= btn_in;
      s      <= s_meta;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      btn_level <= 1'b0;
      dcnt      <= '0;
    end else if (s == btn_level) begin
      dcnt <= '0;
    end else if (accept) begin
      btn_level <= s;
      dcnt      <= '0;
    end else begin
      dcnt <= dcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state       <= REL;
      hcnt        <= '0;
      trigger_out <= 1'b0;
      clear_out   <= 1'b0;
      run_en      <= 1'b0;
    end else begin
      trigger_out <= 1'b0;
      clear_out   <= 1'b0;
      case (state)
        REL: begin
          if (level_rise) begin
            state <= HELD;
            hcnt  <= '0;
          end
        end
        HELD: begin
          hcnt <= hcnt + CNT_W'(1);
          // A release on the terminal-count cycle still counts as a short press.
          if (level_fall) begin
            state       <= REL;
            trigger_out <= 1'b1;
            run_en      <= ~run_en;
          end else if (hcnt == LONG_LAST) begin
            state     <= LONGHELD;
            clear_out <= 1'b1;
            run_en    <= 1'b0;
          end
        end
        LONGHELD: begin
          // hcnt is left at its saturated value until the next press.
          if (level_fall) begin
            state <= REL;
          end
        end
        default: begin
          state <= REL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_trigger_gen.sv
// Directed bench for stopwatch_trigger_gen with short debounce/long-press counts;
// expected pulse kinds are queued per press and matched by a pulse monitor.
module tb_stopwatch_trigger_gen;

  localparam logic [1:0] TRIG = 2'b01;
  localparam logic [1:0] CLR  = 2'b10;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic trigger_out;
  logic clear_out;
  logic run_en;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];

  stopwatch_trigger_gen #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .CNT_W            (27)
  ) dut (
    .sys_clk    (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .trigger_out(trigger_out),
    .clear_out  (clear_out),
    .run_en     (run_en)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pulse monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (trigger_out || clear_out) begin
      if (exp_q.size() == 0) check("pulse_spurious", {clear_out, trigger_out}, 2'b00);
      else check("pulse_kind", {clear_out, trigger_out}, exp_q.pop_front());
    end
  end

  // Press with btn_in high for 'hold' cycles; the pulse is expected 'pulse_at' edges
  // after btn_in went high. btn_level rises 6 edges after press, falls 6 after release.
  task automatic press(input int hold, input int pulse_at, input logic [1:0] kind,
                       input logic run_before, input logic run_after, input string tag);
    int last;
    last = ((hold > pulse_at) ? hold : pulse_at) + 8;
    exp_q.push_back(kind);
    btn_in = 1'b1;
    for (int t = 1; t <= last; t++) begin
      step();
      if (t == hold) btn_in = 1'b0;
      if (t == 5) check({tag, "_lvl_pre"}, btn_level, 1'b0);
      if (t == 6) check({tag, "_lvl_rise"}, btn_level, 1'b1);
      if (t == hold + 5) check({tag, "_lvl_hold"}, btn_level, 1'b1);
      if (t == hold + 6) check({tag, "_lvl_fall"}, btn_level, 1'b0);
      if (t == pulse_at) begin
        check({tag, "_pulse"}, {clear_out, trigger_out}, kind);
        check({tag, "_run_after"}, run_en, run_after);
      end else begin
        check({tag, "_no_pulse"}, {clear_out, trigger_out}, 2'b00);
        check({tag, "_run"}, run_en, (t < pulse_at) ? run_before : run_after);
      end
    end
    check({tag, "_lvl_end"}, btn_level, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;

    // 1: outputs stay 0 under reset even with btn_in toggling, and after release
    for (int i = 0; i < 10; i++) begin
      step();
      btn_in = ~btn_in;
      check("rst_hold_outs", {btn_level, trigger_out, clear_out, run_en}, 4'b0000);
    end
    btn_in = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_idle_outs", {btn_level, trigger_out, clear_out, run_en}, 4'b0000);
    end

    // 2: two short presses toggle run_en 0->1->0
    press(12, 18, TRIG, 1'b0, 1'b1, "short1");
    press(12, 18, TRIG, 1'b1, 1'b0, "short2");

    // 3: glitches of 1..3 cycles are rejected
    for (int g = 1; g <= 3; g++) begin
      btn_in = 1'b1;
      for (int i = 0; i < g; i++) begin
        step();
        check("glitch_lvl", btn_level, 1'b0);
      end
      btn_in = 1'b0;
      step();
      check("glitch_lvl", btn_level, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check("glitch_quiet", {btn_level, trigger_out, clear_out, run_en}, 4'b0000);
    end

    // 4: long press while running clears and stops, no trigger on release
    press(12, 18, TRIG, 1'b0, 1'b1, "short3");
    press(40, 26, CLR, 1'b1, 1'b0, "long40");
    press(21, 26, CLR, 1'b0, 1'b0, "long21");

    // 5: release lands on the terminal-count cycle, short press wins
    press(20, 26, TRIG, 1'b0, 1'b1, "tie20");

    // 6: asynchronous reset mid-HELD, then the still-held button is a new press
    btn_in = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("mid_held_lvl", btn_level, 1'b1);
    check("mid_held_run", run_en, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_lvl", btn_level, 1'b0);
    check("async_rst_run", run_en, 1'b0);
    check("async_rst_pulses", {clear_out, trigger_out}, 2'b00);
    step();
    reset = 1'b0;
    press(10, 16, TRIG, 1'b0, 1'b1, "after_rst");

    repeat (4) step();
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
